// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// - DataCtrl size/sign encoding, shared with the data RAM and the decoder.
// - FSM state enum.
// - Base byte-enable helper function.
package lsu_pkg;

    localparam logic [2:0] CTRL_WORD  = 3'b000;
    localparam logic [2:0] CTRL_HALF  = 3'b001;
    localparam logic [2:0] CTRL_BYTE  = 3'b010;
    localparam logic [2:0] CTRL_UHALF = 3'b101;
    localparam logic [2:0] CTRL_UBYTE = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ0 = 3'd1,
        ST_RSP0 = 3'd2,
        ST_REQ1 = 3'd3,
        ST_RSP1 = 3'd4,
        ST_DONE = 3'd5
    } lsu_state_e;

    // Byte enables of an access at offset 0.
    // Unknown codes behave as word.
    function automatic logic [3:0] base_be(input logic [2:0] ctrl);
        logic [3:0] be;
        case (ctrl)
            CTRL_HALF, CTRL_UHALF: be = 4'b0011;
            CTRL_BYTE, CTRL_UBYTE: be = 4'b0001;
            default:               be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment for the load/store unit.
// Inputs:
//   ctrl    - DataCtrl size/sign code.
//   off     - byte offset, address bits [1:0].
//   wdata   - right-justified store data.
//   rdata0  - first word read.
//   rdata1  - second word read (0 when the access is aligned).
// Outputs:
//   be8       - 8-lane byte enables over the two words.
//   wd64      - lane-aligned store data; disabled lanes are 0.
//   rdata_ext - shifted and extended load data.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  ctrl,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata0,
    input  logic [31:0] rdata1,
    output logic [7:0]  be8,
    output logic [63:0] wd64,
    output logic [31:0] rdata_ext
);

    logic [63:0] wd_shift_s;
    logic [63:0] rd_shift_s;

    // Byte enables and masked store data across two consecutive words.
    always_comb begin
        be8        = {4'b0000, base_be(ctrl)} << off;
        wd_shift_s = {32'd0, wdata} << {off, 3'b000};
        wd64       = 64'd0;
        for (int i = 0; i < 8; i++) begin
            if (be8[i]) begin
                wd64[8*i +: 8] = wd_shift_s[8*i +: 8];
            end else begin
                wd64[8*i +: 8] = 8'h00;
            end
        end
    end

    // Bring the addressed bytes down to bit 0, then extend by size/sign.
    always_comb begin
        rd_shift_s = {rdata1, rdata0} >> {off, 3'b000};
        case (ctrl)
            CTRL_HALF:  rdata_ext = {{16{rd_shift_s[15]}}, rd_shift_s[15:0]};
            CTRL_BYTE:  rdata_ext = {{24{rd_shift_s[7]}}, rd_shift_s[7:0]};
            CTRL_UHALF: rdata_ext = {16'd0, rd_shift_s[15:0]};
            CTRL_UBYTE: rdata_ext = {24'd0, rd_shift_s[7:0]};
            default:    rdata_ext = rd_shift_s[31:0];
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: the initiator side of the CPU data-memory interface.
// Accepts one load or store per req_valid/req_ready handshake.
// Issues one aligned word access, or two when the access straddles a word
// boundary, and returns a one-cycle resp_valid pulse.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset.
//   req_valid/ready/we/ctrl/addr/wdata - pipeline request side.
//   resp_valid, resp_rdata         - completion pulse and extended load data.
//   mem_req/gnt/we/addr/be/wdata   - word-aligned memory access side.
//   mem_rdata                      - read data, one cycle after the grant.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_ctrl,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             mem_req,
    input  logic             mem_gnt,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [3:0]       mem_be,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    lsu_state_e  state_r;
    logic        we_r;
    logic [2:0]  ctrl_r;
    logic [1:0]  off_r;
    logic [3:0]  be_hi_r;
    logic [31:0] wd_hi_r;
    logic [31:0] rdata0_r;

    logic [2:0]  al_ctrl_s;
    logic [1:0]  al_off_s;
    logic [31:0] al_rdata0_s;
    logic [31:0] al_rdata1_s;
    logic [7:0]  be8_s;
    logic [63:0] wd64_s;
    logic [31:0] rdata_ext_s;

    assign req_ready = (state_r == ST_IDLE);

    // The aligner sees the live request while idle.
    // Once accepted, it sees the registered copy.
    always_comb begin
        if (state_r == ST_IDLE) begin
            al_ctrl_s = req_ctrl;
            al_off_s  = req_addr[1:0];
        end else begin
            al_ctrl_s = ctrl_r;
            al_off_s  = off_r;
        end
    end

    // Read words fed to the merger.
    // In RSP1 the second word arrives live and the first is held.
    // Otherwise this is a single-word response.
    always_comb begin
        if (state_r == ST_RSP1) begin
            al_rdata0_s = rdata0_r;
            al_rdata1_s = mem_rdata;
        end else begin
            al_rdata0_s = mem_rdata;
            al_rdata1_s = 32'd0;
        end
    end

    lsu_align u_align (
        .ctrl      (al_ctrl_s),
        .off       (al_off_s),
        .wdata     (req_wdata),
        .rdata0    (al_rdata0_s),
        .rdata1    (al_rdata1_s),
        .be8       (be8_s),
        .wd64      (wd64_s),
        .rdata_ext (rdata_ext_s)
    );

    // Access sequencing FSM with registered memory and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            we_r       <= 1'b0;
            ctrl_r     <= CTRL_WORD;
            off_r      <= 2'b00;
            be_hi_r    <= 4'b0000;
            wd_hi_r    <= 32'd0;
            rdata0_r   <= 32'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_be     <= 4'b0000;
            mem_wdata  <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_r      <= req_we;
                        ctrl_r    <= req_ctrl;
                        off_r     <= req_addr[1:0];
                        // The second-word lanes are kept for a possible split access.
                        be_hi_r   <= be8_s[7:4];
                        wd_hi_r   <= wd64_s[63:32];
                        mem_req   <= 1'b1;
                        mem_we    <= req_we;
                        mem_addr  <= {req_addr[31:2], 2'b00};
                        mem_be    <= be8_s[3:0];
                        mem_wdata <= wd64_s[31:0];
                        state_r   <= ST_REQ0;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_REQ0: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state_r <= ST_RSP0;
                    end else begin
                        state_r <= ST_REQ0;
                    end
                end
                ST_RSP0: begin
                    rdata0_r <= mem_rdata;
                    if (be_hi_r != 4'b0000) begin
                        mem_req   <= 1'b1;
                        mem_addr  <= mem_addr + 32'd4;
                        mem_be    <= be_hi_r;
                        mem_wdata <= wd_hi_r;
                        state_r   <= ST_REQ1;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_rdata <= we_r ? 32'd0 : rdata_ext_s;
                        state_r    <= ST_DONE;
                    end
                end
                ST_REQ1: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state_r <= ST_RSP1;
                    end else begin
                        state_r <= ST_REQ1;
                    end
                end
                ST_RSP1: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= we_r ? 32'd0 : rdata_ext_s;
                    state_r    <= ST_DONE;
                end
                ST_DONE: begin
                    resp_valid <= 1'b0;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    resp_valid <= 1'b0;
                    mem_req    <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit, backed by a small word memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_ctrl;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        preload;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_ctrl   (req_ctrl),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Word memory (16 words, aliased on addr[5:2]); read data one cycle after grant.
    logic [31:0] mem [0:15];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
            mem[0]  <= 32'h44332211;
            mem[1]  <= 32'h88776655;
            mem[15] <= 32'hDEADBEEF;
        end else if (mem_req && mem_gnt) begin
            if (mem_we) begin
                for (int i = 0; i < 4; i++)
                    if (mem_be[i]) mem[mem_addr[5:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
            end else begin
                mem_rdata <= mem[mem_addr[5:2]];
            end
        end
    end

    // Per-transaction observations recorded by run().
    int          lat;
    int          nacc;
    logic [31:0] acc_addr [0:3];
    logic [3:0]  acc_be   [0:3];
    logic [31:0] acc_wd   [0:3];
    logic [31:0] got_rdata;
    logic        ready_after;
    logic        valid_after;
    logic        cyc_req   [0:20];
    logic [31:0] cyc_addr  [0:20];
    logic [3:0]  cyc_be    [0:20];
    logic        cyc_ready [0:20];

    // Issue one request at the current negedge (cycle T) and observe until one cycle after resp.
    task automatic run(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                       input logic [31:0] wdata, input int lo_start, input int lo_len);
        lat = -1;
        nacc = 0;
        ready_after = 1'b0;
        valid_after = 1'b1;
        req_valid = 1'b1;
        req_we = we;
        req_ctrl = ctrl;
        req_addr = addr;
        req_wdata = wdata;
        mem_gnt = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                // Scramble the request fields; the DUT must use its registered copy.
                req_valid = 1'b0;
                req_we = ~we;
                req_ctrl = 3'b010;
                req_addr = 32'h0000_0003;
                req_wdata = 32'h5A5A_5A5A;
            end
            mem_gnt = (k >= lo_start && k < lo_start + lo_len) ? 1'b0 : 1'b1;
            cyc_req[k] = mem_req;
            cyc_addr[k] = mem_addr;
            cyc_be[k] = mem_be;
            cyc_ready[k] = req_ready;
            if (mem_req && mem_gnt && nacc < 4) begin
                acc_addr[nacc] = mem_addr;
                acc_be[nacc] = mem_be;
                acc_wd[nacc] = mem_wdata;
                nacc++;
            end
            if (lat > 0) begin
                ready_after = req_ready;
                valid_after = resp_valid;
                mem_gnt = 1'b1;
                break;
            end else if (resp_valid) begin
                lat = k;
                got_rdata = resp_rdata;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        preload = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_ctrl = 3'b000;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        mem_gnt = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        preload = 1'b0;
        @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, mem_req, mem_we, mem_be} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_ctl got %b exp 10000000",
                     {req_ready, resp_valid, mem_req, mem_we, mem_be});
        end
        checks++;
        if ({resp_rdata, mem_addr, mem_wdata} !== 96'd0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h exp 0", resp_rdata, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_aligned_load();
        run(1'b0, 3'b000, 32'h100, 32'd0, 0, 0);
        checks++;
        if (lat !== 3 || nacc !== 1) begin
            errors++;
            $display("FAIL lw100_lat got lat %0d nacc %0d exp 3 1", lat, nacc);
        end
        checks++;
        if (acc_addr[0] !== 32'h100 || acc_be[0] !== 4'b1111) begin
            errors++;
            $display("FAIL lw100_acc got %h %b exp 00000100 1111", acc_addr[0], acc_be[0]);
        end
        checks++;
        if (got_rdata !== 32'h44332211) begin
            errors++;
            $display("FAIL lw100_data got %h exp 44332211", got_rdata);
        end
        checks++;
        if (ready_after !== 1'b1 || valid_after !== 1'b0) begin
            errors++;
            $display("FAIL lw100_after got ready %b valid %b exp 1 0", ready_after, valid_after);
        end
    endtask

    task automatic test_subword_load();
        run(1'b0, 3'b010, 32'h107, 32'd0, 0, 0);
        checks++;
        if (lat !== 3 || acc_addr[0] !== 32'h104 || acc_be[0] !== 4'b1000) begin
            errors++;
            $display("FAIL lb107_acc got lat %0d %h %b exp 3 00000104 1000",
                     lat, acc_addr[0], acc_be[0]);
        end
        checks++;
        if (got_rdata !== 32'hFFFFFF88) begin
            errors++;
            $display("FAIL lb107_data got %h exp ffffff88", got_rdata);
        end
        run(1'b0, 3'b110, 32'h107, 32'd0, 0, 0);
        checks++;
        if (got_rdata !== 32'h00000088) begin
            errors++;
            $display("FAIL lbu107_data got %h exp 00000088", got_rdata);
        end
        run(1'b0, 3'b101, 32'h106, 32'd0, 0, 0);
        checks++;
        if (got_rdata !== 32'h00008877 || acc_be[0] !== 4'b1100) begin
            errors++;
            $display("FAIL lhu106 got %h be %b exp 00008877 1100", got_rdata, acc_be[0]);
        end
    endtask

    task automatic test_split_load();
        run(1'b0, 3'b000, 32'h102, 32'd0, 0, 0);
        checks++;
        if (lat !== 5 || nacc !== 2) begin
            errors++;
            $display("FAIL lw102_lat got lat %0d nacc %0d exp 5 2", lat, nacc);
        end
        checks++;
        if (acc_addr[0] !== 32'h100 || acc_be[0] !== 4'b1100 ||
            acc_addr[1] !== 32'h104 || acc_be[1] !== 4'b0011) begin
            errors++;
            $display("FAIL lw102_acc got %h %b %h %b exp 00000100 1100 00000104 0011",
                     acc_addr[0], acc_be[0], acc_addr[1], acc_be[1]);
        end
        checks++;
        if (got_rdata !== 32'h66554433) begin
            errors++;
            $display("FAIL lw102_data got %h exp 66554433", got_rdata);
        end
        run(1'b0, 3'b001, 32'h103, 32'd0, 0, 0);
        checks++;
        if (acc_be[0] !== 4'b1000 || acc_be[1] !== 4'b0001 || got_rdata !== 32'h00005544) begin
            errors++;
            $display("FAIL lh103 got be %b %b data %h exp 1000 0001 00005544",
                     acc_be[0], acc_be[1], got_rdata);
        end
    endtask

    task automatic test_wrap();
        run(1'b0, 3'b000, 32'hFFFFFFFE, 32'd0, 0, 0);
        checks++;
        if (acc_addr[0] !== 32'hFFFFFFFC || acc_addr[1] !== 32'h00000000 ||
            got_rdata !== 32'h2211DEAD) begin
            errors++;
            $display("FAIL wrap got %h %h data %h exp fffffffc 00000000 2211dead",
                     acc_addr[0], acc_addr[1], got_rdata);
        end
    endtask

    task automatic test_grant_stall();
        logic stable_ok;
        logic busy_ok;
        run(1'b0, 3'b000, 32'h102, 32'd0, 3, 3);
        checks++;
        if (lat !== 8 || got_rdata !== 32'h66554433) begin
            errors++;
            $display("FAIL stall_lat got lat %0d data %h exp 8 66554433", lat, got_rdata);
        end
        stable_ok = 1'b1;
        for (int k = 3; k <= 6; k++)
            if (cyc_req[k] !== 1'b1 || cyc_addr[k] !== 32'h104 || cyc_be[k] !== 4'b0011)
                stable_ok = 1'b0;
        checks++;
        if (stable_ok !== 1'b1) begin
            errors++;
            $display("FAIL stall_stable got %b %h %b at k=4 exp 1 00000104 0011",
                     cyc_req[4], cyc_addr[4], cyc_be[4]);
        end
        busy_ok = 1'b1;
        for (int k = 1; k <= 8; k++)
            if (cyc_ready[k] !== 1'b0) busy_ok = 1'b0;
        checks++;
        if (busy_ok !== 1'b1 || ready_after !== 1'b1) begin
            errors++;
            $display("FAIL stall_ready got busy_ok %b after %b exp 1 1", busy_ok, ready_after);
        end
    endtask

    task automatic test_reset_midflight();
        logic seen_valid;
        req_valid = 1'b1;
        req_we = 1'b0;
        req_ctrl = 3'b000;
        req_addr = 32'h102;
        req_wdata = 32'd0;
        mem_gnt = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({req_ready, mem_req, resp_valid, mem_be} !== 7'b1000000 ||
            mem_addr !== 32'd0 || resp_rdata !== 32'd0) begin
            errors++;
            $display("FAIL midrst got ready %b req %b valid %b be %b addr %h rdata %h exp 1 0 0 0000 0 0",
                     req_ready, mem_req, resp_valid, mem_be, mem_addr, resp_rdata);
        end
        rst = 1'b0;
        seen_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) seen_valid = 1'b1;
        end
        checks++;
        if (seen_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_novalid got %b exp 0", seen_valid);
        end
        run(1'b0, 3'b000, 32'h104, 32'd0, 0, 0);
        checks++;
        if (lat !== 3 || got_rdata !== 32'h88776655) begin
            errors++;
            $display("FAIL midrst_lw104 got lat %0d data %h exp 3 88776655", lat, got_rdata);
        end
    endtask

    task automatic test_store();
        run(1'b1, 3'b000, 32'h101, 32'hAABBCCDD, 0, 0);
        checks++;
        if (lat !== 5 || got_rdata !== 32'd0) begin
            errors++;
            $display("FAIL sw101_lat got lat %0d rdata %h exp 5 0", lat, got_rdata);
        end
        checks++;
        if (acc_addr[0] !== 32'h100 || acc_be[0] !== 4'b1110 || acc_wd[0] !== 32'hBBCCDD00) begin
            errors++;
            $display("FAIL sw101_acc0 got %h %b %h exp 00000100 1110 bbccdd00",
                     acc_addr[0], acc_be[0], acc_wd[0]);
        end
        checks++;
        if (acc_addr[1] !== 32'h104 || acc_be[1] !== 4'b0001 || acc_wd[1] !== 32'h000000AA) begin
            errors++;
            $display("FAIL sw101_acc1 got %h %b %h exp 00000104 0001 000000aa",
                     acc_addr[1], acc_be[1], acc_wd[1]);
        end
        checks++;
        if (mem[0] !== 32'hBBCCDD11 || mem[1] !== 32'h887766AA) begin
            errors++;
            $display("FAIL sw101_mem got %h %h exp bbccdd11 887766aa", mem[0], mem[1]);
        end
        run(1'b1, 3'b010, 32'h10A, 32'h12345678, 0, 0);
        checks++;
        if (lat !== 3 || acc_addr[0] !== 32'h108 || acc_be[0] !== 4'b0100 ||
            acc_wd[0] !== 32'h00780000) begin
            errors++;
            $display("FAIL sb10a got lat %0d %h %b %h exp 3 00000108 0100 00780000",
                     lat, acc_addr[0], acc_be[0], acc_wd[0]);
        end
        run(1'b0, 3'b000, 32'h100, 32'd0, 0, 0);
        checks++;
        if (got_rdata !== 32'hBBCCDD11) begin
            errors++;
            $display("FAIL sw_readback got %h exp bbccdd11", got_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_aligned_load();
        test_subword_load();
        test_split_load();
        test_wrap();
        test_grant_stall();
        test_reset_midflight();
        test_store();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the CPU data-memory interface. Sits between the execute/memory pipeline stage and the byte-addressable data RAM. Accepts one load or store per handshake using the data RAM's `DataCtrl` size/sign encoding, and issues aligned word accesses with byte enables to memory. Misaligned accesses are split into two word accesses; returned data is merged, shifted and extended before a one-cycle response pulse.

## Interface
- `WIDTH`, 32, data/address width; only 32 is supported.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: pipeline request present.
- `req_ready` out 1: block idle and able to accept.
- `req_we` in 1: 1 = store, 0 = load.
- `req_ctrl` in 3: 000 word, 001 half, 010 byte, 101 uhalf, 110 ubyte; other codes are treated as word.
- `req_addr` in WIDTH: byte address.
- `req_wdata` in WIDTH: store data, right-justified.
- `resp_valid` out 1: one-cycle completion pulse for loads and stores.
- `resp_rdata` out WIDTH: extended load data; 0 for stores.
- `mem_req` out 1: memory access request.
- `mem_gnt` in 1: memory accepts the access this cycle.
- `mem_we` out 1: write access.
- `mem_addr` out WIDTH: word-aligned address, bits [1:0] = 0.
- `mem_be` out 4: byte enables, bit i = byte lane i.
- `mem_wdata` out WIDTH: lane-aligned write data.
- `mem_rdata` in WIDTH: read data, valid exactly one cycle after the `mem_gnt` cycle.

## Operation
- `off = req_addr[1:0]`; base enables: word 1111, half 0011, byte 0001.
- `be8 = base << off` (8-bit).
  - `be8[7:4] == 0` means aligned: one access to `addr & ~3` with `be8[3:0]`.
  - Otherwise split: first access to `addr & ~3` with `be8[3:0]`, second access to `(addr & ~3) + 4` with `be8[7:4]`.
  - Misaligned cases: word with off ≠ 0; half with off = 3.
- Store data: `wd64 = req_wdata << 8*off`. The first access carries `wd64[31:0]` and the second carries `wd64[63:32]`. Disabled lanes drive 0.
- Load data: `rd64 = {rdata1, rdata0} >> 8*off`, where `rdata1 = 0` when aligned. Then:
  - half: sign-extend bit 15.
  - byte: sign-extend bit 7.
  - uhalf / ubyte: zero-extend.
  - word: pass through.
- Address arithmetic wraps modulo 2^32.
- All request fields are registered on acceptance; later changes to `req_*` have no effect.
- States:
  - IDLE: `req_ready` = 1. On `req_valid`, go to REQ0.
  - REQ0: `mem_req` = 1. Stay until `mem_gnt`, then go to RSP0.
  - RSP0: capture `mem_rdata` into rdata0. Go to REQ1 if split, else DONE.
  - REQ1: `mem_req` = 1 for the second access. Stay until `mem_gnt`, then go to RSP1.
  - RSP1: capture rdata1. Go to DONE.
  - DONE: `resp_valid` = 1. Go to IDLE.
- Stores traverse the same states; their captured rdata is ignored.

## Timing
- Reset values:
  - `req_ready` = 1, `resp_valid` = 0, `resp_rdata` = 0.
  - `mem_req` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_be` = 0, `mem_wdata` = 0.
  - state = IDLE.
- Memory-side outputs and `resp_*` are registered. `req_ready` decodes state only.
- Latency from the accept cycle T with `mem_gnt` tied high:
  - aligned access: `resp_valid` at T+3.
  - split access: `resp_valid` at T+5.
  - each cycle of `mem_gnt` low adds one cycle.
- While `mem_req` = 1 and `mem_gnt` = 0, `mem_addr`, `mem_be`, `mem_we` and `mem_wdata` are held stable.
- `mem_req` drops in the cycle after the grant; there are no back-to-back accesses without an RSP cycle.
- No new request is accepted in DONE. The earliest next accept is the cycle after DONE.
- `resp_rdata` holds its value until the next DONE.
- Reset asserted in any state:
  - next cycle is IDLE with all outputs at reset values.
  - a granted half of a split store is not rolled back.

## Structure
- `lsu_pkg`: `DataCtrl` encoding constants (`CTRL_WORD`, `CTRL_HALF`, `CTRL_BYTE`, `CTRL_UHALF`, `CTRL_UBYTE`) shared with the data RAM and decoder, plus the state enum.
- Sub-module `lsu_align`: purely combinational. Computes `be8` and `wd64` from (ctrl, off, wdata), and computes extended load data from (ctrl, off, rdata0, rdata1).
- The top level contains the FSM and registers only.

## Test plan
Memory preload: 0x100 = 0x44332211, 0x104 = 0x88776655. `mem_gnt` is high unless stated.
1. lw 0x100 → one access: `mem_addr` 0x100, `mem_be` 1111; `resp_rdata` 0x44332211 with `resp_valid` at T+3.
2. lb 0x107 → `mem_be` 1000 at 0x104; `resp_rdata` 0xFFFFFF88. lbu 0x107 → 0x00000088. lhu 0x106 → 0x00008877.
3. lw 0x102 → access 0x100 with be 1100, then 0x104 with be 0011; `resp_rdata` 0x66554433 at T+5. lh 0x103 → be 1000 then 0001; `resp_rdata` 0x00005544.
4. sw 0xAABBCCDD to 0x101 → 0x100 with be 1110, wdata 0xBBCCDD00; then 0x104 with be 0001, wdata 0x000000AA; memory becomes 0xBBCCDD11 / 0x887766AA.
5. `mem_gnt` low for 3 cycles during REQ1 of case 3 → `mem_addr`/`mem_be` stable throughout; `resp_valid` at T+8; `req_ready` = 0 throughout.
6. `rst` pulsed during RSP0 of a split load → next cycle: IDLE, `req_ready` 1, `mem_req` 0, no `resp_valid`; a following lw 0x104 returns 0x88776655.
